// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: parametrised IEEE 1149.1 TAP controller with IDCODE,
// BYPASS and NumUser contiguous user DR channels.
//
// Ports
//   tck_i, trst_ni            test clock, async active-low reset
//   tms_i, td_i               TAP mode select and serial data in
//   td_o, tdo_oe_o            serial data out and its enable (falling-edge launch)
//   testmode_i                1 = launch TDO on the rising edge (no inversion)
//   tap_state_o               current state encoding (0..15)
//   test_logic_reset_o .. update_ir_o   state strobes
//   ir_o                      latched instruction
//   user_sel_o                one-hot user channel select
//   user_tdi_o                shared TDI towards the user channels
//   user_tdo_i                serial data back from each user channel
//
// User channels keep their own DR; they qualify capture/shift/update
// strobes with their user_sel_o bit.
module jtag_tap_multi #(
    parameter int unsigned         IrLength       = 5,
    parameter logic [31:0]         IdcodeValue    = 32'h0000_0001,
    parameter logic [IrLength-1:0] IrCaptureValue = 'b00101,
    parameter int unsigned         NumUser        = 2,
    parameter int unsigned         UserIrBase     = 'h10
) (
    input  logic                tck_i,
    input  logic                trst_ni,
    input  logic                tms_i,
    input  logic                td_i,
    output logic                td_o,
    output logic                tdo_oe_o,
    input  logic                testmode_i,
    output logic [3:0]          tap_state_o,
    output logic                test_logic_reset_o,
    output logic                run_test_idle_o,
    output logic                capture_dr_o,
    output logic                shift_dr_o,
    output logic                pause_dr_o,
    output logic                update_dr_o,
    output logic                update_ir_o,
    output logic [IrLength-1:0] ir_o,
    output logic [NumUser-1:0]  user_sel_o,
    output logic                user_tdi_o,
    input  logic [NumUser-1:0]  user_tdo_i
);

    typedef enum logic [3:0] {
        TestLogicReset = 4'd0,
        RunTestIdle    = 4'd1,
        SelectDrScan   = 4'd2,
        CaptureDr      = 4'd3,
        ShiftDr        = 4'd4,
        Exit1Dr        = 4'd5,
        PauseDr        = 4'd6,
        Exit2Dr        = 4'd7,
        UpdateDr       = 4'd8,
        SelectIrScan   = 4'd9,
        CaptureIr      = 4'd10,
        ShiftIr        = 4'd11,
        Exit1Ir        = 4'd12,
        PauseIr        = 4'd13,
        Exit2Ir        = 4'd14,
        UpdateIr       = 4'd15
    } tap_state_e;

    localparam logic [IrLength-1:0] IrIdcode = IrLength'(1);

    tap_state_e          state, state_next;
    logic [IrLength-1:0] ir, ir_shift;
    logic [NumUser-1:0]  user_sel, user_dec;
    logic [31:0]         idcode_shift;
    logic                bypass;
    logic                idcode_sel;
    logic                tdo_mux;
    logic                shifting;
    logic                tck_n, tck_launch;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) state <= TestLogicReset;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TestLogicReset: state_next = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   state_next = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      state_next = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        state_next = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        state_next = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        state_next = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        state_next = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       state_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   state_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      state_next = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        state_next = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        state_next = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        state_next = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        state_next = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       state_next = tms_i ? SelectDrScan   : RunTestIdle;
            default:        state_next = TestLogicReset;
        endcase
    end

    assign tap_state_o        = state;
    assign test_logic_reset_o = (state == TestLogicReset);
    assign run_test_idle_o    = (state == RunTestIdle);
    assign capture_dr_o       = (state == CaptureDr);
    assign shift_dr_o         = (state == ShiftDr);
    assign pause_dr_o         = (state == PauseDr);
    assign update_dr_o        = (state == UpdateDr);
    assign update_ir_o        = (state == UpdateIr);
    assign shifting           = (state == ShiftIr) || (state == ShiftDr);

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    // Decode the shift register so user_sel is registered together with
    // ir and never sees a combinational path from the pads.
    always_comb begin
        user_dec = '0;
        for (int k = 0; k < int'(NumUser); k++) begin
            user_dec[k] = (32'(ir_shift) == (UserIrBase + 32'(k)));
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_shift <= '0;
            ir       <= IrIdcode;
            user_sel <= '0;
        end else begin
            unique case (state)
                TestLogicReset: begin
                    ir_shift <= '0;
                    ir       <= IrIdcode;
                    user_sel <= '0;
                end
                CaptureIr: ir_shift <= IrCaptureValue;
                ShiftIr:   ir_shift <= {td_i, ir_shift[IrLength-1:1]};
                UpdateIr: begin
                    ir       <= ir_shift;
                    user_sel <= user_dec;
                end
                default: ;
            endcase
        end
    end

    assign ir_o       = ir;
    assign user_sel_o = user_sel;
    assign user_tdi_o = td_i;
    assign idcode_sel = (ir == IrIdcode);

    // ------------------------------------------------------------------
    // IDCODE and BYPASS data registers
    // ------------------------------------------------------------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            idcode_shift <= IdcodeValue;
            bypass       <= 1'b0;
        end else begin
            unique case (state)
                TestLogicReset: begin
                    idcode_shift <= IdcodeValue;
                    bypass       <= 1'b0;
                end
                CaptureDr: begin
                    if (idcode_sel) idcode_shift <= IdcodeValue;
                    bypass <= 1'b0;
                end
                ShiftDr: begin
                    if (idcode_sel) idcode_shift <= {td_i, idcode_shift[31:1]};
                    bypass <= td_i;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TDO select and launch
    // ------------------------------------------------------------------
    // Anything that is neither IDCODE nor a user opcode falls back to BYPASS.
    always_comb begin
        tdo_mux = bypass;
        if (state == ShiftIr)  tdo_mux = ir_shift[0];
        else if (idcode_sel)   tdo_mux = idcode_shift[0];
        else if (|user_sel)    tdo_mux = |(user_sel & user_tdo_i);
    end

    // Launch clock: inverted TCK in mission mode so TDO changes half a
    // cycle ahead of the capturing rising edge; plain TCK under DFT so the
    // launch flops sit in the same clock domain as the rest of the scan.
    assign tck_n      = ~tck_i;
    assign tck_launch = testmode_i ? tck_i : tck_n;

    always_ff @(posedge tck_launch or negedge trst_ni) begin
        if (!trst_ni) begin
            td_o     <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            tdo_oe_o <= shifting;
            if (shifting) td_o <= tdo_mux;
        end
    end

endmodule
